// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - switch-driven LED pattern controller with debounce, prescaler and pause
module led_pattern_ctrl #(
  parameter int LED_W      = 8,
  parameter int SW_W       = 4,
  parameter int TICK_DIV   = 12_500_000,
  parameter int DEB_CYCLES = 250_000
) (
  input  logic             ext_clk_25m,
  input  logic             ext_rst_n,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic [1:0]       mode
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(TICK_DIV / 4 - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LED_W-1:0] LED_ONE   = {{(LED_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_RUN    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [SW_W-1:0]  sync1_q, sync2_q, sync2_dly_q;
  logic [SW_W-1:0]  sw_db_q, sw_db_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [LED_W-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       mode_prev_q;

  logic [LED_W-1:0] sw_led;
  logic [1:0]       mode_sel;
  logic             reload;
  logic             paused;
  logic [CNT_W-1:0] cnt_last;
  logic             step;

  // Debounced switches as seen on the LEDs in static mode
  if (LED_W > SW_W) begin : g_sw_ext
    assign sw_led = {{(LED_W-SW_W){1'b0}}, sw_db_q};
  end else if (LED_W == SW_W) begin : g_sw_eq
    assign sw_led = sw_db_q;
  end else begin : g_sw_trunc
    assign sw_led = sw_db_q[LED_W-1:0];
  end

  assign mode_sel = sw_db_q[1:0];
  assign reload   = (mode_sel != mode_prev_q);
  assign paused   = sw_db_q[3];
  assign cnt_last = sw_db_q[2] ? FAST_LAST : SLOW_LAST;

  // Debounce: accept the synchronised vector after DEB_CYCLES stable differing cycles
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    sw_db_d   = sw_db_q;
    if ((sync2_q == sw_db_q) || (sync2_q != sync2_dly_q)) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      sw_db_d   = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Prescaler, pause and per-mode LED pattern next state; a mode reload beats everything
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    led_d  = led_q;
    dir_d  = dir_q;
    step   = 1'b0;
    if (reload) begin
      cnt_d = '0;
      dir_d = DIR_UP;
      case (mode_sel)
        MODE_STATIC: led_d = sw_led;
        MODE_RUN:    led_d = LED_ONE;
        MODE_BOUNCE: led_d = LED_ONE;
        default:     led_d = '0;
      endcase
    end else if (!paused) begin
      if (cnt_q >= cnt_last) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        step   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      case (mode_sel)
        MODE_STATIC: led_d = sw_led;
        MODE_RUN: begin
          if (step) led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        end
        MODE_BOUNCE: begin
          if (step) begin
            if (dir_q == DIR_UP) begin
              led_d = led_q << 1;
              if (led_d[LED_W-1]) dir_d = DIR_DOWN;
            end else begin
              led_d = led_q >> 1;
              if (led_d[0]) dir_d = DIR_UP;
            end
          end
        end
        MODE_COUNT: begin
          if (step) led_d = led_q + 1'b1;
        end
        default: led_d = led_q;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync2_dly_q <= '0;
      sw_db_q     <= '0;
      deb_cnt_q   <= '0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      led_q       <= '0;
      dir_q       <= DIR_UP;
      mode_prev_q <= '0;
    end else begin
      sync1_q     <= switch;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      sw_db_q     <= sw_db_d;
      deb_cnt_q   <= deb_cnt_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      mode_prev_q <= sw_db_q[1:0];
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
  assign mode = sw_db_q[1:0];

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

  localparam int LED_W      = 8;
  localparam int SW_W       = 4;
  localparam int TICK_DIV   = 8;
  localparam int DEB_CYCLES = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_r  = 4'b0001;
  logic [7:0] led;
  logic       tick;
  logic [1:0] mode;

  int vecs     = 0;
  int errs     = 0;
  int j        = 0;
  int cur_mode = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .LED_W     (LED_W),
    .SW_W      (SW_W),
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .ext_clk_25m(clk),
    .ext_rst_n  (rst_n),
    .switch     (sw_r),
    .led        (led),
    .tick       (tick),
    .mode       (mode)
  );

  // Pattern after n ticks since a reload, from the mode's definition
  function automatic logic [7:0] exp_led(input int m, input int n, input logic [3:0] sw);
    int p;
    case (m)
      0: return {4'b0000, sw};
      1: return 8'(1 << (n % 8));
      2: begin
        p = n % 14;
        return 8'(1 << ((p <= 7) ? p : 14 - p));
      end
      default: return 8'(n % 256);
    endcase
  endfunction

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Switch change: mode moves 6 edges after the first sampling edge, reload one edge later
  task automatic apply_mode(input logic [3:0] sw);
    int old;
    int nm;
    old  = cur_mode;
    nm   = int'(sw[1:0]);
    sw_r = sw;
    for (int e = 1; e <= 8; e++) begin
      step_clk();
      if (e == 6) begin
        vecs++;
        if (mode !== 2'(old)) begin
          errs++;
          $display("FAIL mode_hold: got %0d expected %0d", mode, old);
        end
      end
      if (e == 7) begin
        vecs++;
        if (mode !== 2'(nm)) begin
          errs++;
          $display("FAIL mode_change: got %0d expected %0d", mode, nm);
        end
      end
      if (e == 8) begin
        vecs++;
        if (led !== exp_led(nm, 0, sw) || tick !== 1'b0) begin
          errs++;
          $display("FAIL reload: led %02h tick %0b expected led %02h tick 0",
                   led, tick, exp_led(nm, 0, sw));
        end
      end
    end
    cur_mode = nm;
    j = 0;
  endtask

  // Cycle-by-cycle check of tick spacing and pattern since the last reload
  task automatic run_check(input int ncyc, input logic [3:0] sw);
    int lim;
    logic [7:0] el;
    logic et;
    lim = sw[2] ? TICK_DIV / 4 : TICK_DIV;
    for (int c = 0; c < ncyc; c++) begin
      step_clk();
      j++;
      et = (j % lim == 0);
      el = exp_led(cur_mode, j / lim, sw);
      vecs++;
      if (tick !== et || led !== el || mode !== 2'(cur_mode)) begin
        errs++;
        $display("FAIL seq m%0d j%0d: led %02h tick %0b mode %0d expected led %02h tick %0b mode %0d",
                 cur_mode, j, led, tick, mode, el, et, cur_mode);
      end
    end
  endtask

  task automatic test_reset();
    sw_r  = 4'b0001;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (led !== 8'h00 || tick !== 1'b0 || mode !== 2'd0) begin
      errs++;
      $display("FAIL reset: led %02h tick %0b mode %0d expected 00 0 0", led, tick, mode);
    end
    rst_n = 1'b1;
    apply_mode(4'b0001);
  endtask

  task automatic test_run();
    run_check(9 * 8 + 3, 4'b0001);
  endtask

  task automatic test_bounce();
    apply_mode(4'b0010);
    run_check(16 * 8, 4'b0010);
  endtask

  task automatic test_count_fast();
    apply_mode(4'b0111);
    run_check(260 * 2, 4'b0111);
  endtask

  task automatic test_random();
    int m;
    logic [3:0] sw;
    for (int i = 0; i < 6; i++) begin
      do begin
        m = int'($urandom % 4);
      end while (m == cur_mode || (i == 5 && m == 1));
      sw = {1'b0, 1'($urandom % 2), 2'(m)};
      apply_mode(sw);
      run_check(int'($urandom_range(20, 120)), sw);
    end
  endtask

  task automatic test_glitch_pause();
    logic [7:0] frozen;
    apply_mode(4'b0001);
    run_check(13, 4'b0001);
    sw_r = 4'b0011;
    run_check(3, 4'b0001);
    sw_r = 4'b0001;
    run_check(40, 4'b0001);
    sw_r = 4'b1001;
    run_check(7, 4'b0001);
    frozen = exp_led(1, j / TICK_DIV, 4'b0001);
    for (int c = 0; c < 20; c++) begin
      step_clk();
      vecs++;
      if (tick !== 1'b0 || led !== frozen) begin
        errs++;
        $display("FAIL pause: led %02h tick %0b expected %02h 0", led, tick, frozen);
      end
    end
    sw_r = 4'b1011;
    for (int e = 1; e <= 28; e++) begin
      step_clk();
      vecs++;
      if (e <= 7) begin
        if (tick !== 1'b0 || led !== frozen) begin
          errs++;
          $display("FAIL pause_pre: led %02h tick %0b expected %02h 0", led, tick, frozen);
        end
      end else if (tick !== 1'b0 || led !== 8'h00 || mode !== 2'd3) begin
        errs++;
        $display("FAIL pause_reload: led %02h tick %0b mode %0d expected 00 0 3",
                 led, tick, mode);
      end
    end
    cur_mode = 3;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    sw_r = 4'b0111;
    for (int c = 0; c < 1500 && !found; c++) begin
      step_clk();
      if (led === 8'h2A) found = 1'b1;
    end
    vecs++;
    if (!found) begin
      errs++;
      $display("FAIL count_reach: led %02h never reached 2a", led);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (led !== 8'h00 || tick !== 1'b0 || mode !== 2'd0) begin
      errs++;
      $display("FAIL async_reset: led %02h tick %0b mode %0d expected 00 0 0", led, tick, mode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_mode = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_run();
    test_bounce();
    test_count_fast();
    test_random();
    test_glitch_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised LED pattern controller for the sp6 board top, succeeding the fixed 8-LED driver. It synchronises and debounces the slide switches, derives a step tick from the 25 MHz board clock, and drives LED_W LEDs in one of four switch-selected modes, with speed and pause controls. The block is instantiated directly under the sp6 top between the `switch` inputs and the `led` outputs.

## Interface
- LED_W, 8: number of LEDs driven; must be 2 or more.
- SW_W, 4: switch count; must be 4 or more. Bits [1:0] select the mode, bit 2 selects fast, bit 3 selects pause.
- TICK_DIV, 12_500_000: clock cycles per pattern step in normal speed; must be a multiple of 4 and 4 or more.
- DEB_CYCLES, 250_000: required stable cycles before a switch change is accepted; must be 1 or more.
- ext_clk_25m  input  1  board clock; all state is on the rising edge.
- ext_rst_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised by the top.
- switch  input  SW_W  raw, asynchronous slide switches.
- led  output  LED_W  registered LED drive; 1 = lit.
- tick  output  1  one-cycle strobe on each pattern step.
- mode  output  2  debounced mode, equal to sw_db[1:0].

## Operation
- **Reset values:** led=0, tick=0, mode=0. All internal state also resets: sync flops, sw_db, debounce counter, prescaler and direction (dir=up).
- **Synchroniser:** switch → s1 → s2, a 2-flop synchroniser. s2_q is s2 delayed by one cycle.
- **Debounce** acts on the whole vector:
  - The counter clears when s2==sw_db or s2!=s2_q.
  - Otherwise it increments.
  - When the condition holds with the counter at DEB_CYCLES-1, sw_db<=s2 and the counter clears.
- **Prescaler:**
  - limit = TICK_DIV when sw_db[2]=0, and TICK_DIV/4 when sw_db[2]=1.
  - When cnt ≥ limit-1, tick<=1 and cnt<=0. Otherwise cnt increments and tick<=0.
  - A speed change that leaves cnt ≥ limit-1 produces a tick on the next edge.
- **Pause (sw_db[3]=1):** the prescaler, tick (held 0), led and dir are frozen. The mode-change reload still applies.
- **Mode change** (sw_db[1:0] differs from its previous-cycle value): on the next edge, led loads the new mode's initial value, cnt<=0, dir<=up and tick<=0. A reload takes priority over a coincident tick.
- **Mode 0 STATIC:** led follows the zero-extended sw_db every cycle, truncated if LED_W<SW_W. Ticks are ignored.
- **Mode 1 RUN:**
  - Initial value: led=1 (LSB).
  - Each tick rotates led left; the MSB wraps to bit 0.
- **Mode 2 BOUNCE:**
  - Initial value: led=1, dir=up.
  - Each tick, a single lit bit shifts toward the MSB when dir=up and toward the LSB when dir=down.
  - The step that lands on bit LED_W-1 sets dir=down; the step that lands on bit 0 sets dir=up.
  - The sequence period is 2·LED_W-2 ticks.
- **Mode 3 COUNT:**
  - Initial value: led=0.
  - Each tick, led increments modulo 2^LED_W, so all-ones wraps to 0.

## Timing
- **Switch latency:** a switch change that is stable from clock edge k first appears in sw_db at edge k+DEB_CYCLES+2.
  - `mode` changes on that same edge.
  - The led reload follows one edge later.
- **Glitch rejection:** any pulse shorter than DEB_CYCLES+1 cycles at s2 is rejected.
- **Tick period:** consecutive ticks are exactly `limit` cycles apart. tick is high for one cycle.
- **Step latency:** led updates on the same edge that raises tick.
- **Reset:** asserting ext_rst_n at any point forces all outputs to their reset values immediately, with no clock needed. After release, operation resumes with mode 0.

## Test plan
Use LED_W=8, SW_W=4, TICK_DIV=8, DEB_CYCLES=4 throughout.
1. **Reset:** hold ext_rst_n=0 with switch=4'b0001 → led=0x00, tick=0, mode=0. After release and debounce → mode=1 and led=0x01 one edge later.
2. **RUN:** switch=4'b0001 → ticks every 8 cycles; led steps 0x01,0x02,…,0x80,0x01.
3. **BOUNCE:** switch=4'b0010 → led steps 0x01,0x02,…,0x80,0x40,…,0x01,0x02, with a period of 14 ticks.
4. **COUNT fast:** switch=4'b0111 → ticks every 2 cycles; led steps 0x00,0x01,…,0xFF,0x00.
5. **Glitch and pause:**
   - A 3-cycle pulse to 4'b0011 while in mode 1 → mode stays 1, led sequence undisturbed.
   - Setting switch[3]=1 → tick stays 0 and led is frozen.
   - Changing to mode 3 while paused → led=0x00 and still frozen.
6. **Reset mid-run:** in COUNT with led=0x2A, assert ext_rst_n between clock edges → led=0x00, tick=0 and mode=0 with no clock edge.
